// File: rtl/dr_resp_stub.sv
// Directory response stub: answers each L2 request with a snack and each displacement with a dack,
// echoing the source nid after a fixed delay; each channel is an in-order queue.
package dr_resp_stub_pkg;

    typedef struct packed {
        logic [4:0]  nid;
        logic [5:0]  l2id;
        logic [4:0]  cmd;
        logic [49:0] paddr;
    } I_l2todr_req_type;

    typedef struct packed {
        logic [4:0]  nid;
        logic [5:0]  l2id;
        logic [5:0]  drid;
        logic [4:0]  snack;
        logic [63:0] line;
    } I_drtol2_snack_type;

    typedef struct packed {
        logic [4:0]  nid;
        logic [5:0]  l2id;
        logic [5:0]  drid;
        logic [15:0] mask;
        logic [1:0]  dcmd;
        logic [63:0] line;
        logic [49:0] paddr;
    } I_l2todr_disp_type;

    typedef struct packed {
        logic [4:0] nid;
        logic [5:0] l2id;
    } I_drtol2_dack_type;

endpackage

// One response channel: nid queue with a head delay counter.
// Head becomes valid LAT cycles after it reaches the head; retry = queue full.
module dr_resp_q #(
    parameter int QDEPTH = 4,
    parameter int LAT    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_retry,
    input  logic [4:0] in_nid,
    output logic       out_valid,
    input  logic       out_retry,
    output logic [4:0] out_nid
);
    localparam int AW = $clog2(QDEPTH);

    logic [4:0]    mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    delay;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count == (AW+1)'(QDEPTH));
    assign push      = in_valid && !full;
    assign out_valid = (count != '0) && (delay == 4'd0);
    assign pop       = out_valid && !out_retry;
    assign in_retry  = full;
    assign out_nid   = out_valid ? mem[rd_ptr] : 5'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            delay  <= 4'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A new head always waits the full delay, including a push that refills a queue being drained.
            if ((push && count == '0) || (pop && (count > (AW+1)'(1) || push)))
                delay <= 4'(LAT);
            else if (delay != 4'd0)
                delay <= delay - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_nid;
    end

endmodule

// Top: two independent channels, req->snack and disp->dack; outputs are zero except nid.
// First response LAT+1 cycles after acceptance; retry on an output holds valid and payload.
module dr_resp_stub
    import dr_resp_stub_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int LAT    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l2todr_req_valid,
    output logic               l2todr_req_retry,
    input  I_l2todr_req_type   l2todr_req,
    output logic               drtol2_snack_valid,
    input  logic               drtol2_snack_retry,
    output I_drtol2_snack_type drtol2_snack,
    input  logic               l2todr_disp_valid,
    output logic               l2todr_disp_retry,
    input  I_l2todr_disp_type  l2todr_disp,
    output logic               drtol2_dack_valid,
    input  logic               drtol2_dack_retry,
    output I_drtol2_dack_type  drtol2_dack
);
    logic [4:0] snack_nid;
    logic [4:0] dack_nid;

    // Only the nid travels through; the rest of each payload is deliberately ignored.
    logic payload_unused;
    assign payload_unused = ^{l2todr_req.l2id, l2todr_req.cmd, l2todr_req.paddr,
                              l2todr_disp.l2id, l2todr_disp.drid, l2todr_disp.mask,
                              l2todr_disp.dcmd, l2todr_disp.line, l2todr_disp.paddr};

    dr_resp_q #(.QDEPTH(QDEPTH), .LAT(LAT)) u_req_q (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (l2todr_req_valid),
        .in_retry  (l2todr_req_retry),
        .in_nid    (l2todr_req.nid),
        .out_valid (drtol2_snack_valid),
        .out_retry (drtol2_snack_retry),
        .out_nid   (snack_nid)
    );

    dr_resp_q #(.QDEPTH(QDEPTH), .LAT(LAT)) u_disp_q (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (l2todr_disp_valid),
        .in_retry  (l2todr_disp_retry),
        .in_nid    (l2todr_disp.nid),
        .out_valid (drtol2_dack_valid),
        .out_retry (drtol2_dack_retry),
        .out_nid   (dack_nid)
    );

    always_comb begin
        drtol2_snack     = '0;
        drtol2_snack.nid = snack_nid;
        drtol2_dack      = '0;
        drtol2_dack.nid  = dack_nid;
    end

endmodule

// File: tb/tb_dr_resp_stub.sv
// Directed bench for dr_resp_stub: LAT=3 instance for most scenarios, LAT=0 instance for streaming.
module tb_dr_resp_stub;
    import dr_resp_stub_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               req_valid, req_retry, snack_valid, snack_retry;
    logic               disp_valid, disp_retry, dack_valid, dack_retry;
    I_l2todr_req_type   req;
    I_drtol2_snack_type snack;
    I_l2todr_disp_type  disp;
    I_drtol2_dack_type  dack;

    logic               z_req_valid, z_req_retry, z_snack_valid, z_snack_retry;
    logic               z_disp_valid, z_disp_retry, z_dack_valid, z_dack_retry;
    I_l2todr_req_type   z_req;
    I_drtol2_snack_type z_snack;
    I_l2todr_disp_type  z_disp;
    I_drtol2_dack_type  z_dack;

    int checks = 0;
    int errors = 0;

    dr_resp_stub #(.QDEPTH(4), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .l2todr_req_valid(req_valid), .l2todr_req_retry(req_retry), .l2todr_req(req),
        .drtol2_snack_valid(snack_valid), .drtol2_snack_retry(snack_retry), .drtol2_snack(snack),
        .l2todr_disp_valid(disp_valid), .l2todr_disp_retry(disp_retry), .l2todr_disp(disp),
        .drtol2_dack_valid(dack_valid), .drtol2_dack_retry(dack_retry), .drtol2_dack(dack)
    );

    dr_resp_stub #(.QDEPTH(4), .LAT(0)) dut0 (
        .clk(clk), .reset(reset),
        .l2todr_req_valid(z_req_valid), .l2todr_req_retry(z_req_retry), .l2todr_req(z_req),
        .drtol2_snack_valid(z_snack_valid), .drtol2_snack_retry(z_snack_retry), .drtol2_snack(z_snack),
        .l2todr_disp_valid(z_disp_valid), .l2todr_disp_retry(z_disp_retry), .l2todr_disp(z_disp),
        .drtol2_dack_valid(z_dack_valid), .drtol2_dack_retry(z_dack_retry), .drtol2_dack(z_dack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic I_drtol2_snack_type exp_snack(input logic [4:0] nid);
        I_drtol2_snack_type s;
        s = '0;
        s.nid = nid;
        return s;
    endfunction

    function automatic I_drtol2_dack_type exp_dack(input logic [4:0] nid);
        I_drtol2_dack_type d;
        d = '0;
        d.nid = nid;
        return d;
    endfunction

    task automatic set_req(input logic [4:0] nid);
        req       = '0;
        req.nid   = nid;
        req.l2id  = 6'h2a;
        req.cmd   = 5'h13;
        req.paddr = 50'h3_dead_beef_cafe;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({snack_valid, dack_valid, req_retry, disp_retry} !== 4'b0000 ||
            snack !== '0 || dack !== '0) begin
            errors++;
            $display("FAIL reset_state: valid/retry=%b%b%b%b snack=%h dack=%h required all 0",
                     snack_valid, dack_valid, req_retry, disp_retry, snack, dack);
        end
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        set_req(5'b01010);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            checks++;
            if (snack_valid !== 1'b0 || snack !== '0) begin
                errors++;
                $display("FAIL single_early: cycle %0d valid=%b snack=%h required 0", i, snack_valid, snack);
            end
            tick();
        end
        checks++;
        if (snack_valid !== 1'b1 || snack !== exp_snack(5'b01010)) begin
            errors++;
            $display("FAIL single_resp: valid=%b snack=%h required 1 %h", snack_valid, snack, exp_snack(5'b01010));
        end
        tick();
        checks++;
        if (snack_valid !== 1'b0 || snack !== '0) begin
            errors++;
            $display("FAIL single_after_pop: valid=%b snack=%h required 0", snack_valid, snack);
        end
    endtask

    task automatic test_fill();
        logic [4:0] got [$];
        logic       take;
        snack_retry = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req(5'(k + 1));
            req_valid = 1'b1;
            checks++;
            if (req_retry !== (k == 4)) begin
                errors++;
                $display("FAIL fill_retry: offer %0d retry=%b required %b", k, req_retry, (k == 4));
            end
            if (k < 4) tick();
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (req_retry !== 1'b1 || snack_valid !== 1'b1 || snack.nid !== 5'd1) begin
            errors++;
            $display("FAIL fill_held: retry=%b valid=%b nid=%0d required 1 1 1", req_retry, snack_valid, snack.nid);
        end
        snack_retry = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (snack_valid && !snack_retry) got.push_back(snack.nid);
            take = req_valid && !req_retry;
            tick();
            if (take) req_valid = 1'b0;
        end
        checks++;
        if (got.size() != 5 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_count: snacks=%0d req_pending=%b required 5 0", got.size(), req_valid);
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] !== 5'(i + 1)) begin
                errors++;
                $display("FAIL fill_order: snack %0d nid=%0d required %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_stall();
        snack_retry = 1'b1;
        set_req(5'b11001);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (snack_valid !== 1'b1 || snack !== exp_snack(5'b11001)) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b snack=%h required 1 %h",
                         i, snack_valid, snack, exp_snack(5'b11001));
            end
            tick();
        end
        snack_retry = 1'b0;
        tick();
        for (int i = 0; i < LAT + 2; i++) begin
            checks++;
            if (snack_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_single_pop: cycle %0d valid=%b required 0", i, snack_valid);
            end
            tick();
        end
    endtask

    task automatic test_stream_lat0();
        for (int t = 0; t < 10; t++) begin
            z_req       = '0;
            z_req.nid   = 5'(t + 8);
            z_req.paddr = 50'h1234;
            z_req_valid = (t < 8);
            if (t >= 1 && t <= 8) begin
                checks++;
                if (z_req_retry !== 1'b0 || z_snack_valid !== 1'b1 || z_snack !== exp_snack(5'(t + 7))) begin
                    errors++;
                    $display("FAIL stream: cycle %0d retry=%b valid=%b snack=%h required 0 1 %h",
                             t, z_req_retry, z_snack_valid, z_snack, exp_snack(5'(t + 7)));
                end
            end
            tick();
        end
        checks++;
        if (z_snack_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained: valid=%b required 0", z_snack_valid);
        end
    endtask

    task automatic test_concurrency();
        set_req(5'b10011);
        disp      = '0;
        disp.nid  = 5'b01101;
        disp.mask = 16'hffff;
        disp.line = 64'h0123_4567_89ab_cdef;
        req_valid  = 1'b1;
        disp_valid = 1'b1;
        tick();
        req_valid  = 1'b0;
        disp_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            checks++;
            if (snack_valid !== 1'b0 || dack_valid !== 1'b0) begin
                errors++;
                $display("FAIL conc_early: cycle %0d snack_valid=%b dack_valid=%b required 0 0", i, snack_valid, dack_valid);
            end
            tick();
        end
        checks++;
        if (snack_valid !== 1'b1 || snack !== exp_snack(5'b10011) ||
            dack_valid !== 1'b1 || dack !== exp_dack(5'b01101)) begin
            errors++;
            $display("FAIL conc_resp: snack %b %h dack %b %h required 1 %h 1 %h", snack_valid, snack,
                     dack_valid, dack, exp_snack(5'b10011), exp_dack(5'b01101));
        end
        tick();
        checks++;
        if (snack_valid !== 1'b0 || dack_valid !== 1'b0 || dack !== '0) begin
            errors++;
            $display("FAIL conc_pop: snack_valid=%b dack_valid=%b dack=%h required 0", snack_valid, dack_valid, dack);
        end
    endtask

    task automatic test_reset_mid();
        snack_retry = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_req(5'(21 + k));
            req_valid = 1'b1;
            tick();
        end
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        checks++;
        if (snack_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: valid=%b required 1", snack_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (snack_valid !== 1'b0 || req_retry !== 1'b0 || snack !== '0) begin
            errors++;
            $display("FAIL rst_mid_immediate: valid=%b retry=%b snack=%h required 0", snack_valid, req_retry, snack);
        end
        tick();
        reset = 1'b0;
        snack_retry = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            checks++;
            if (snack_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_discard: cycle %0d valid=%b required 0", i, snack_valid);
            end
            tick();
        end
        set_req(5'd30);
        req_valid = 1'b1;
        checks++;
        if (req_retry !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_accept: retry=%b required 0", req_retry);
        end
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < LAT; i++) tick();
        checks++;
        if (snack_valid !== 1'b1 || snack !== exp_snack(5'd30)) begin
            errors++;
            $display("FAIL rst_mid_new: valid=%b snack=%h required 1 %h", snack_valid, snack, exp_snack(5'd30));
        end
        tick();
    endtask

    initial begin
        req_valid = 1'b0;  snack_retry = 1'b0;  disp_valid = 1'b0;  dack_retry = 1'b0;
        req = '0;  disp = '0;
        z_req_valid = 1'b0;  z_snack_retry = 1'b0;  z_disp_valid = 1'b0;  z_dack_retry = 1'b0;
        z_req = '0;  z_disp = '0;
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_stream_lat0();
        test_concurrency();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
